lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the multicycle RISC-V core datapath and the 32-bit SPRAM-backed data RAM.
- Accepts one load/store command at a time from the core FSM and drives a word-aligned memory address, lane-shifted write data and a positional byte mask.
- Waits out the RAM read latency, then returns the extracted, sign- or zero-extended load result.
- Detects misaligned and illegal accesses and never issues a memory cycle for them.

Parameters:
- READ_LATENCY, 1, cycles from the first cycle memAddress is presented until memReadData is valid (range 1..4).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- lsuStart  in  1  command strobe; sampled only in IDLE
- lsuWrite  in  1  1 = store, 0 = load
- funct3  in  3  RISC-V funct3 of the load/store instruction
- addr  in  ADDR_W  byte address
- storeData  in  32  store operand, value in low bits
- lsuBusy  out  1  high from the cycle after an accepted lsuStart until lsuDone
- lsuDone  out  1  one-cycle completion pulse
- lsuFault  out  1  valid with lsuDone: misaligned or illegal funct3
- loadResult  out  32  extended load data; updated only on successful load completion
- memAddress  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}
- memWriteData  out  32  storeData replicated/shifted to the byte lane
- memWrite  out  1  write enable, one cycle per store
- byteMask  out  4  positional lane enables, bit i = byte lane i
- memReadData  in  32  RAM read data

Behaviour:
- Reset values:
  - lsuBusy, lsuDone, lsuFault, memWrite = 0
  - byteMask = 4'b0000
  - memAddress, memWriteData, loadResult = 0
  - state = IDLE
- Reset mid-operation: the next edge returns to IDLE. No lsuDone, memWrite deasserts, any in-flight load data is discarded.
- States: IDLE, ACCESS, WAIT, DONE.
- Command capture: in IDLE, lsuStart=1 latches lsuWrite, funct3, addr and storeData.
  - If the command faults, go to DONE.
  - Otherwise go to ACCESS.
  - lsuStart in any other state is ignored and the command is not queued.
- Fault rules:
  - Halfword with addr[0]=1 faults.
  - Word with addr[1:0]!=0 faults.
  - Load funct3 in {011,110,111} faults.
  - Store funct3[2]=1 or funct3=011 faults.
  - A faulting command never asserts memWrite and does not change loadResult.
- ACCESS (1 cycle): memAddress, byteMask and memWriteData are driven from registers.
  - Store: memWrite=1 for exactly this cycle, next state DONE.
  - Load: memWrite=0, byteMask=0, next state WAIT with counter = READ_LATENCY-1.
- WAIT: memAddress stays stable.
  - Counter decrements each cycle.
  - When the counter is 0, memReadData is captured, extracted and extended into loadResult at that edge; next state DONE.
- DONE (1 cycle): lsuDone=1, lsuFault as computed, lsuBusy=0 in this cycle; next state IDLE.
- Latency from the lsuStart cycle (cycle 0):
  - Store: lsuDone in cycle 2.
  - Load: lsuDone in cycle 2+READ_LATENCY, i.e. cycle 3 by default.
  - Fault: lsuDone in cycle 1.
- Store lane rules:
  - SB: mask = 1<<addr[1:0], data = {4{storeData[7:0]}}.
  - SH: mask = addr[1] ? 1100 : 0011, data = {2{storeData[15:0]}}.
  - SW: mask = 1111, data = storeData.
- Load extraction:
  - LB/LBU: byte lane addr[1:0].
  - LH/LHU: half lane addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Back-to-back: the next lsuStart is accepted in IDLE, the cycle after DONE at the earliest. lsuStart asserted during DONE is ignored.

Decomposition:
- Shared package lsu_pkg:
  - state enum lsu_state_t {IDLE, ACCESS, WAIT, DONE}
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
- One combinational sub-module lsu_align: funct3 plus addr[1:0] in; byteMask, shifted write data, extracted/extended load data and fault flag out. Shared by the store and load paths.

Test Plan:
- SW addr=0x100, storeData=0xDEADBEEF -> cycle 1: memAddress=0x100, byteMask=1111, memWrite=1, memWriteData=0xDEADBEEF; lsuDone in cycle 2, lsuFault=0.
- SB addr=0x103, storeData=0x000000A5 -> byteMask=1000, memWriteData=0xA5A5A5A5, memAddress=0x100, a single memWrite cycle.
- LB addr=0x102 with memReadData=0x1280FF00 -> loadResult=0xFFFFFF80 at lsuDone (cycle 3). LBU at the same address -> 0x00000080. LHU addr=0x102 -> 0x00001280.
- LW addr=0x101 and SH addr=0x203 -> lsuDone+lsuFault in cycle 1, memWrite never high, loadResult unchanged.
- READ_LATENCY=3, LW addr=0x40 -> memAddress held 0x40 for 4 cycles, lsuDone in cycle 5; lsuStart pulses while busy are ignored.
- Reset asserted in WAIT -> next cycle IDLE, lsuBusy=0, no lsuDone, loadResult=0.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit: FSM
//                state encoding and RISC-V load/store funct3 codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Load/store controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  // funct3 encodings shared by loads and stores (BU/HU are load-only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of the read-latency down-counter (latency 1..4 -> count 0..3)
  localparam int CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic for the load/store unit. Produces
//                the store byte mask and lane-replicated write data, extracts
//                and extends load data, and flags misaligned/illegal accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_write,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  byte_mask,
  output logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the read word
  always_comb begin
    byte_sel = read_data[7:0];
    case (addr_lo)
      2'd0:    byte_sel = read_data[7:0];
      2'd1:    byte_sel = read_data[15:8];
      2'd2:    byte_sel = read_data[23:16];
      default: byte_sel = read_data[31:24];
    endcase
    half_sel = addr_lo[1] ? read_data[31:16] : read_data[15:0];
  end

  // Decode access size into lane enables, write data, load data and fault
  always_comb begin
    fault      = 1'b0;
    byte_mask  = 4'b0000;
    write_data = store_data;
    load_data  = read_data;
    if (is_write) begin
      case (funct3)
        F3_B: begin
          byte_mask  = 4'b0001 << addr_lo;
          write_data = {4{store_data[7:0]}};
        end
        F3_H: begin
          byte_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
          write_data = {2{store_data[15:0]}};
          fault      = addr_lo[0];
        end
        F3_W: begin
          byte_mask  = 4'b1111;
          write_data = store_data;
          fault      = (addr_lo != 2'b00);
        end
        default: fault = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
        F3_BU: load_data = {24'd0, byte_sel};
        F3_H: begin
          load_data = {{16{half_sel[15]}}, half_sel};
          fault     = addr_lo[0];
        end
        F3_HU: begin
          load_data = {16'd0, half_sel};
          fault     = addr_lo[0];
        end
        F3_W: begin
          load_data = read_data;
          fault     = (addr_lo != 2'b00);
        end
        default: fault = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_master
//  Description : Single-outstanding load/store initiator between the core
//                datapath and the 32-bit data RAM. Aligns the address, places
//                store data on the right byte lanes, waits out the RAM read
//                latency and returns extended load data. Faulting commands
//                complete immediately without touching memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsuStart,
  input  logic              lsuWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       storeData,
  output logic              lsuBusy,
  output logic              lsuDone,
  output logic              lsuFault,
  output logic [31:0]       loadResult,
  output logic [ADDR_W-1:0] memAddress,
  output logic [31:0]       memWriteData,
  output logic              memWrite,
  output logic [3:0]        byteMask,
  input  logic [31:0]       memReadData
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(READ_LATENCY - 1);

  lsu_state_t        state;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [ADDR_W-1:0] addr_q;
  logic              fault_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       load_q;

  logic              is_idle;
  logic [2:0]        al_f3;
  logic [1:0]        al_lo;
  logic              al_wr;
  logic [3:0]        al_mask;
  logic [31:0]       al_wdata;
  logic [31:0]       al_load;
  logic              al_fault;

  // In IDLE the aligner classifies the incoming command; afterwards it
  // works on the latched command so the load path can extract read data.
  assign is_idle = (state == IDLE);
  assign al_f3   = is_idle ? funct3   : f3_q;
  assign al_lo   = is_idle ? addr[1:0] : lo_q;
  assign al_wr   = is_idle ? lsuWrite : write_q;

  lsu_align u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .is_write   (al_wr),
    .store_data (storeData),
    .read_data  (memReadData),
    .byte_mask  (al_mask),
    .write_data (al_wdata),
    .load_data  (al_load),
    .fault      (al_fault)
  );

  // Command capture, access sequencing and load-result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      write_q <= 1'b0;
      f3_q    <= 3'b000;
      lo_q    <= 2'b00;
      addr_q  <= '0;
      fault_q <= 1'b0;
      mask_q  <= 4'b0000;
      wdata_q <= 32'd0;
      cnt     <= '0;
      load_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (lsuStart) begin
            write_q <= lsuWrite;
            f3_q    <= funct3;
            lo_q    <= addr[1:0];
            fault_q <= al_fault;
            if (al_fault) begin
              // Faulting commands leave the memory-side registers untouched
              state <= DONE;
            end else begin
              addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mask_q  <= al_mask;
              wdata_q <= al_wdata;
              state   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (write_q) begin
            state <= DONE;
          end else begin
            cnt   <= WAIT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            load_q <= al_load;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state and registered command fields
  always_comb begin
    lsuBusy      = (state == ACCESS) || (state == WAIT);
    lsuDone      = (state == DONE);
    lsuFault     = (state == DONE) && fault_q;
    memWrite     = (state == ACCESS) && write_q;
    byteMask     = memWrite ? mask_q : 4'b0000;
    memAddress   = addr_q;
    memWriteData = wdata_q;
    loadResult   = load_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_master
//  Description : Self-checking bench for lsu_mem_master. Two instances run
//                the same command stream, one with read latency 1 and one
//                with read latency 3, each behind its own RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;
  import lsu_pkg::*;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic        flt;
    logic [31:0] ld;
    logic [3:0]  mk;
    logic [31:0] wd;
    logic        poke;
  } vec_t;

  typedef struct {
    logic        flt;
    logic [31:0] res;
    int          cyc;
  } dexp_t;

  typedef struct {
    logic [31:0] ma;
    logic [3:0]  mk;
    logic [31:0] wd;
    int          cyc;
  } wexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        lsuStart  = 1'b0;
  logic        lsuWrite  = 1'b0;
  logic [2:0]  funct3    = 3'b000;
  logic [31:0] addr      = 32'd0;
  logic [31:0] storeData = 32'd0;

  logic        busy0, done0, flt0, mw0, busy1, done1, flt1, mw1;
  logic [31:0] res0, ma0, wd0, mrd0, res1, ma1, wd1, mrd1;
  logic [3:0]  mk0, mk1;

  lsu_mem_master #(.READ_LATENCY(1), .ADDR_W(32)) dut (
    .clk(clk), .reset(rst), .lsuStart(lsuStart), .lsuWrite(lsuWrite),
    .funct3(funct3), .addr(addr), .storeData(storeData),
    .lsuBusy(busy0), .lsuDone(done0), .lsuFault(flt0), .loadResult(res0),
    .memAddress(ma0), .memWriteData(wd0), .memWrite(mw0), .byteMask(mk0),
    .memReadData(mrd0)
  );

  lsu_mem_master #(.READ_LATENCY(3), .ADDR_W(32)) dut3 (
    .clk(clk), .reset(rst), .lsuStart(lsuStart), .lsuWrite(lsuWrite),
    .funct3(funct3), .addr(addr), .storeData(storeData),
    .lsuBusy(busy1), .lsuDone(done1), .lsuFault(flt1), .loadResult(res1),
    .memAddress(ma1), .memWriteData(wd1), .memWrite(mw1), .byteMask(mk1),
    .memReadData(mrd1)
  );

  // RAM contents seen by loads
  function automatic logic [31:0] ram_word(logic [31:0] a);
    case (a)
      32'h0000_0100: ram_word = 32'h1280_FF00;
      32'h0000_0200: ram_word = 32'h8001_7FFF;
      32'h0000_0040: ram_word = 32'hCAFE_F00D;
      default:       ram_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Read pipelines: data appears 1 and 3 cycles after the address
  logic [31:0] p0 = 32'd0, p1a = 32'd0, p1b = 32'd0, p1c = 32'd0;
  always @(posedge clk) begin
    p0  <= ram_word(ma0);
    p1a <= ram_word(ma1);
    p1b <= p1a;
    p1c <= p1b;
  end
  assign mrd0 = p0;
  assign mrd1 = p1c;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  dexp_t dq0[$], dq1[$];
  wexp_t wq0[$], wq1[$];
  logic [31:0] cur_addr = 32'd0;
  logic [31:0] last_res = 32'd0;
  vec_t vecs[$];

  task automatic chk(string name, int k, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, got, exp);
    end
  endtask

  // Pops and compares expected responses whenever an instance presents one
  task automatic mon(int k, logic done, logic flt, logic busy, logic [31:0] res,
                     logic mw, logic [3:0] mk, logic [31:0] wd, logic [31:0] ma);
    dexp_t d;
    wexp_t w;
    if (done) begin
      if ((k == 0 && dq0.size() == 0) || (k == 1 && dq1.size() == 0)) begin
        total++; bad++;
        $display("FAIL unexpected_done inst%0d cycle %0d", k, cyc);
      end else begin
        if (k == 0) d = dq0.pop_front(); else d = dq1.pop_front();
        chk("done_cycle", k, cyc, d.cyc);
        chk("fault", k, {31'd0, flt}, {31'd0, d.flt});
        chk("load_result", k, res, d.res);
        chk("busy_in_done", k, {31'd0, busy}, 32'd0);
      end
    end
    if (mw) begin
      if ((k == 0 && wq0.size() == 0) || (k == 1 && wq1.size() == 0)) begin
        total++; bad++;
        $display("FAIL unexpected_write inst%0d cycle %0d addr %h", k, cyc, ma);
      end else begin
        if (k == 0) w = wq0.pop_front(); else w = wq1.pop_front();
        chk("write_cycle", k, cyc, w.cyc);
        chk("write_addr", k, ma, w.ma);
        chk("write_mask", k, {28'd0, mk}, {28'd0, w.mk});
        chk("write_data", k, wd, w.wd);
      end
    end
    if (busy) chk("busy_addr", k, ma, cur_addr);
    if (busy && !mw) chk("idle_mask", k, {28'd0, mk}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, done0, flt0, busy0, res0, mw0, mk0, wd0, ma0);
      mon(1, done1, flt1, busy1, res1, mw1, mk1, wd1, ma1);
    end
  end

  // Issue one command, push expectations, wait for both instances to finish
  task automatic run(vec_t v);
    dexp_t d;
    wexp_t w;
    int    t0;
    t0 = cyc;
    if (!v.flt && !v.wr) last_res = v.ld;
    d.flt = v.flt;
    d.res = last_res;
    d.cyc = t0 + (v.flt ? 1 : (v.wr ? 2 : 3));
    dq0.push_back(d);
    d.cyc = t0 + (v.flt ? 1 : (v.wr ? 2 : 5));
    dq1.push_back(d);
    if (!v.flt && v.wr) begin
      w.ma = {v.a[31:2], 2'b00}; w.mk = v.mk; w.wd = v.wd; w.cyc = t0 + 1;
      wq0.push_back(w);
      wq1.push_back(w);
    end
    if (!v.flt) cur_addr = {v.a[31:2], 2'b00};
    lsuStart = 1'b1; lsuWrite = v.wr; funct3 = v.f3; addr = v.a; storeData = v.sd;
    @(posedge clk); #1;
    if (v.poke) begin
      // A competing store while busy / in DONE must be ignored
      lsuWrite = 1'b1; funct3 = F3_W; addr = 32'h300; storeData = 32'h1111_1111;
      @(posedge clk); #1;
    end
    lsuStart = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (dq0.size() == 0 && dq1.size() == 0) break;
      @(posedge clk); #1;
    end
    if (dq0.size() != 0 || dq1.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout addr %h: pending %0d/%0d expected 0/0", v.a, dq0.size(), dq1.size());
      dq0.delete(); dq1.delete(); wq0.delete(); wq1.delete();
    end
  endtask

  initial begin
    //           wr    f3     addr          storeData     flt   load          mask     wdata         poke
    vecs.push_back('{1'b1, F3_W,  32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b1});
    vecs.push_back('{1'b1, F3_B,  32'h103, 32'h000000A5, 1'b0, 32'h0,        4'b1000, 32'hA5A5A5A5, 1'b0});
    vecs.push_back('{1'b0, F3_B,  32'h102, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, F3_BU, 32'h102, 32'h0,        1'b0, 32'h00000080, 4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, F3_HU, 32'h102, 32'h0,        1'b0, 32'h00001280, 4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, F3_W,  32'h101, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b1, F3_H,  32'h203, 32'h12345678, 1'b1, 32'h0,        4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, F3_H,  32'h200, 32'h0,        1'b0, 32'h00007FFF, 4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, F3_H,  32'h202, 32'h0,        1'b0, 32'hFFFF8001, 4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, F3_W,  32'h040, 32'h0,        1'b0, 32'hCAFEF00D, 4'b0000, 32'h0,        1'b1});
    vecs.push_back('{1'b1, F3_H,  32'h202, 32'h1234ABCD, 1'b0, 32'h0,        4'b1100, 32'hABCDABCD, 1'b0});
    vecs.push_back('{1'b1, F3_B,  32'h101, 32'h00000077, 1'b0, 32'h0,        4'b0010, 32'h77777777, 1'b0});
    vecs.push_back('{1'b0, 3'b011, 32'h100, 32'h0,       1'b1, 32'h0,        4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b1, F3_BU, 32'h100, 32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, F3_B,  32'h101, 32'h0,        1'b0, 32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0});
    vecs.push_back('{1'b0, F3_W,  32'h200, 32'h0,        1'b0, 32'h80017FFF, 4'b0000, 32'h0,        1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 0, {31'd0, busy0}, 32'd0);
    chk("rst_done", 0, {31'd0, done0}, 32'd0);
    chk("rst_fault", 0, {31'd0, flt0}, 32'd0);
    chk("rst_memwrite", 0, {31'd0, mw0}, 32'd0);
    chk("rst_mask", 0, {28'd0, mk0}, 32'd0);
    chk("rst_addr", 0, ma0, 32'd0);
    chk("rst_wdata", 0, wd0, 32'd0);
    chk("rst_result", 0, res0, 32'd0);
    chk("rst_busy", 1, {31'd0, busy1}, 32'd0);
    chk("rst_result", 1, res1, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run(vecs[i]);

    // Reset while both instances sit in WAIT: no completion, result cleared
    cur_addr = 32'h40;
    lsuStart = 1'b1; lsuWrite = 1'b0; funct3 = F3_W; addr = 32'h40;
    @(posedge clk); #1;
    lsuStart = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_busy", 0, {31'd0, busy0}, 32'd0);
    chk("post_rst_busy", 1, {31'd0, busy1}, 32'd0);
    chk("post_rst_done", 0, {31'd0, done0}, 32'd0);
    chk("post_rst_result", 0, res0, 32'd0);
    chk("post_rst_result", 1, res1, 32'd0);
    last_res = 32'd0;
    repeat (6) @(posedge clk);
    #1;
    run('{1'b0, F3_B, 32'h102, 32'h0, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0, 1'b0});

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
